// File: rtl/alus_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared scalar ALU pair.
// One issue slot feeds the ALU; results return to the owning requester's response slot.
module alus_arbiter #(
  parameter int unsigned N     = 24,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [N-1:0]     a_0,
  input  logic [N-1:0]     b_0,
  input  logic [2:0]       ctrl_0,
  input  logic             sel_0,
  input  logic [N-1:0]     a_1,
  input  logic [N-1:0]     b_1,
  input  logic [2:0]       ctrl_1,
  input  logic             sel_1,
  output logic [N-1:0]     alu_A,
  output logic [N-1:0]     alu_B,
  output logic [2:0]       alu_ALUControl,
  output logic             alu_ALUSel,
  input  logic [N-1:0]     alu_result,
  input  logic [3:0]       alu_flags,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [N-1:0]     rsp_result_0,
  output logic [N-1:0]     rsp_result_1,
  output logic [3:0]       rsp_flags_0,
  output logic [3:0]       rsp_flags_1,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e           state_q, state_d;
  logic             owner_q;
  logic             last_grant_q;
  logic [N-1:0]     alu_a_q, alu_b_q;
  logic [2:0]       alu_ctrl_q;
  logic             alu_sel_q;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [N-1:0]     rsp_result_0_q, rsp_result_1_q;
  logic [3:0]       rsp_flags_0_q, rsp_flags_1_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic       retire;
  logic       slot_free;
  logic [1:0] grant;
  logic       transfer;
  logic       gnt_idx;

  assign retire    = (state_q == StExec) && (!rsp_valid_q[owner_q] || rsp_ready[owner_q]);
  assign slot_free = (state_q == StIdle) || retire;

  always_comb begin
    grant = 2'b00;
    if (slot_free) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign transfer = |grant;
  assign gnt_idx  = grant[1];

  always_comb begin
    state_d = state_q;
    if (transfer) begin
      state_d = StExec;
    end else if (slot_free) begin
      state_d = StIdle;
    end
  end

  // A retire into a slot wins over the consumer draining it on the same edge.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    for (int i = 0; i < 2; i++) begin
      if (retire && (owner_q == 1'(i))) begin
        rsp_valid_d[i] = 1'b1;
      end else if (rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      owner_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_ctrl_q     <= '0;
      alu_sel_q      <= 1'b0;
      rsp_valid_q    <= '0;
      rsp_result_0_q <= '0;
      rsp_result_1_q <= '0;
      rsp_flags_0_q  <= '0;
      rsp_flags_1_q  <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      if (retire && !owner_q) begin
        rsp_result_0_q <= alu_result;
        rsp_flags_0_q  <= alu_flags;
      end
      if (retire && owner_q) begin
        rsp_result_1_q <= alu_result;
        rsp_flags_1_q  <= alu_flags;
      end
      if (transfer) begin
        owner_q      <= gnt_idx;
        last_grant_q <= gnt_idx;
        alu_a_q      <= gnt_idx ? a_1 : a_0;
        alu_b_q      <= gnt_idx ? b_1 : b_0;
        alu_ctrl_q   <= gnt_idx ? ctrl_1 : ctrl_0;
        alu_sel_q    <= gnt_idx ? sel_1 : sel_0;
      end
      if ((state_q == StExec) && !retire && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // Gate the combinational grant so every output reads zero while reset is held.
  assign req_ready      = rst ? 2'b00 : grant;
  assign alu_A          = alu_a_q;
  assign alu_B          = alu_b_q;
  assign alu_ALUControl = alu_ctrl_q;
  assign alu_ALUSel     = alu_sel_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_result_0   = rsp_result_0_q;
  assign rsp_result_1   = rsp_result_1_q;
  assign rsp_flags_0    = rsp_flags_0_q;
  assign rsp_flags_1    = rsp_flags_1_q;
  assign busy           = (state_q == StExec);
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_alus_arbiter.sv
// Directed bench for alus_arbiter; a small behavioural ALU closes the loop on alu_*.
module tb_alus_arbiter;

  localparam int unsigned N     = 24;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready;
  logic [N-1:0]     a_0, b_0, a_1, b_1;
  logic [2:0]       ctrl_0, ctrl_1;
  logic             sel_0, sel_1;
  logic [N-1:0]     alu_A, alu_B;
  logic [2:0]       alu_ALUControl;
  logic             alu_ALUSel;
  logic [N-1:0]     alu_result;
  logic [3:0]       alu_flags;
  logic [1:0]       rsp_valid, rsp_ready;
  logic [N-1:0]     rsp_result_0, rsp_result_1;
  logic [3:0]       rsp_flags_0, rsp_flags_1;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alus_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .a_0(a_0), .b_0(b_0), .ctrl_0(ctrl_0), .sel_0(sel_0),
    .a_1(a_1), .b_1(b_1), .ctrl_1(ctrl_1), .sel_1(sel_1),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUControl(alu_ALUControl), .alu_ALUSel(alu_ALUSel),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result_0(rsp_result_0), .rsp_result_1(rsp_result_1),
    .rsp_flags_0(rsp_flags_0), .rsp_flags_1(rsp_flags_1),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  // Stand-in ALU: integer add/sub/and/or/xor, fixed point is a Q.8 multiply.
  logic [2*N-1:0] prod;
  always_comb begin
    prod       = {{N{1'b0}}, alu_A} * {{N{1'b0}}, alu_B};
    alu_result = '0;
    alu_flags  = '0;
    if (alu_ALUSel) begin
      alu_result = prod[N+7:8];
      alu_flags  = {alu_result[N-1], alu_result == '0, 1'b0, 1'b1};
    end else begin
      case (alu_ALUControl)
        3'd0:    alu_result = alu_A + alu_B;
        3'd1:    alu_result = alu_A - alu_B;
        3'd2:    alu_result = alu_A & alu_B;
        3'd3:    alu_result = alu_A | alu_B;
        default: alu_result = alu_A ^ alu_B;
      endcase
      alu_flags = {alu_result[N-1], alu_result == '0, 2'b00};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    a_0 = '0; b_0 = '0; ctrl_0 = '0; sel_0 = 1'b0;
    a_1 = '0; b_1 = '0; ctrl_1 = '0; sel_1 = 1'b0;
    tick(); tick();
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("reset_alu_A", 32'(alu_A), 32'h0);
    rst = 1'b0;
    tick();

    // Single op: 5 + 3
    rsp_ready = 2'b11;
    a_0 = 24'd5; b_0 = 24'd3; ctrl_0 = 3'd0; sel_0 = 1'b0; req_valid = 2'b01;
    #1 chk("single_req_ready", 32'(req_ready), 32'h1);
    tick();
    chk("single_alu_A", 32'(alu_A), 32'd5);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_rsp_early", 32'(rsp_valid), 32'h0);
    req_valid = 2'b00;
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_result", 32'(rsp_result_0), 32'd8);
    chk("single_flags", 32'(rsp_flags_0), 32'h0);
    chk("single_idle", 32'(busy), 32'h0);
    tick();
    chk("single_drain", 32'(rsp_valid), 32'h0);

    // Reset mid-op: EXEC with a pending response on requester 0
    rsp_ready = 2'b00;
    a_0 = 24'd1; b_0 = 24'd1; req_valid = 2'b01;
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'h1);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_alu_A", 32'(alu_A), 32'h0);
    chk("async_req_ready", 32'(req_ready), 32'h0);
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("post_reset_rsp", 32'(rsp_valid), 32'h0);
    chk("post_reset_busy", 32'(busy), 32'h0);
    chk("post_reset_stall", 32'(stall_cnt), 32'h0);

    // Contention from reset: 10+1=11 on requester 0, 20-4=16 on requester 1
    rsp_ready = 2'b11;
    a_0 = 24'd10; b_0 = 24'd1;  ctrl_0 = 3'd0;
    a_1 = 24'd20; b_1 = 24'd4;  ctrl_1 = 3'd1; sel_1 = 1'b0;
    req_valid = 2'b11;
    #1 chk("cont_grant0", 32'(req_ready), 32'h1);
    tick();
    chk("cont_alu_A0", 32'(alu_A), 32'd10);
    chk("cont_grant1", 32'(req_ready), 32'h2);
    tick();
    chk("cont_rsp0", 32'(rsp_valid), 32'h1);
    chk("cont_res0", 32'(rsp_result_0), 32'd11);
    chk("cont_alu_A1", 32'(alu_A), 32'd20);
    chk("cont_ctrl1", 32'(alu_ALUControl), 32'd1);
    chk("cont_grant2", 32'(req_ready), 32'h1);
    tick();
    chk("cont_rsp1", 32'(rsp_valid), 32'h2);
    chk("cont_res1", 32'(rsp_result_1), 32'd16);
    chk("cont_alu_A2", 32'(alu_A), 32'd10);
    req_valid = 2'b00;
    tick();
    chk("cont_rsp2", 32'(rsp_valid), 32'h1);
    chk("cont_res2", 32'(rsp_result_0), 32'd11);
    tick();
    chk("cont_done", 32'(rsp_valid), 32'h0);
    chk("cont_idle", 32'(busy), 32'h0);

    // Back-pressure on requester 0 blocks requester 1
    rsp_ready = 2'b10;
    a_0 = 24'd7; b_0 = 24'd1; ctrl_0 = 3'd0; req_valid = 2'b01;
    tick();
    a_0 = 24'd3; b_0 = 24'd3;
    tick();
    a_1 = 24'd9; b_1 = 24'd9; ctrl_1 = 3'd2; req_valid = 2'b10;
    chk("bp_pending", 32'(rsp_valid), 32'h1);
    chk("bp_res_first", 32'(rsp_result_0), 32'd8);
    chk("bp_no_grant", 32'(req_ready), 32'h0);
    chk("bp_stall0", 32'(stall_cnt), 32'd0);
    tick();
    chk("bp_stall1", 32'(stall_cnt), 32'd1);
    chk("bp_hold_A", 32'(alu_A), 32'd3);
    chk("bp_hold_res", 32'(rsp_result_0), 32'd8);
    tick();
    chk("bp_stall2", 32'(stall_cnt), 32'd2);
    tick();
    chk("bp_stall3", 32'(stall_cnt), 32'd3);
    chk("bp_busy", 32'(busy), 32'h1);
    chk("bp_no_grant3", 32'(req_ready), 32'h0);
    rsp_ready = 2'b11;
    #1 chk("bp_release_grant", 32'(req_ready), 32'h2);
    tick();
    chk("bp_rsp0", 32'(rsp_valid), 32'h1);
    chk("bp_res_second", 32'(rsp_result_0), 32'd6);
    chk("bp_alu_A1", 32'(alu_A), 32'd9);
    chk("bp_stall_hold", 32'(stall_cnt), 32'd3);
    req_valid = 2'b00;
    tick();
    chk("bp_rsp1", 32'(rsp_valid), 32'h2);
    chk("bp_res1", 32'(rsp_result_1), 32'd9);
    tick();
    chk("bp_done", 32'(rsp_valid), 32'h0);

    // Fixed point on requester 1: 0x100 * 0x200 in Q.8 = 0x200
    a_1 = 24'h000100; b_1 = 24'h000200; ctrl_1 = 3'd0; sel_1 = 1'b1; req_valid = 2'b10;
    tick();
    chk("fx_sel", 32'(alu_ALUSel), 32'h1);
    chk("fx_busy", 32'(busy), 32'h1);
    req_valid = 2'b00;
    tick();
    chk("fx_rsp", 32'(rsp_valid), 32'h2);
    chk("fx_result", 32'(rsp_result_1), 32'h200);
    chk("fx_flags", 32'(rsp_flags_1), 32'h1);

    // Saturation: stall continuously from stall_cnt=3 for 20 cycles
    rsp_ready = 2'b00;
    a_0 = 24'd1; b_0 = 24'd1; ctrl_0 = 3'd0; req_valid = 2'b01;
    tick();
    tick();
    req_valid = 2'b00;
    repeat (20) tick();
    chk("sat_stall", 32'(stall_cnt), 32'd15);
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'd15);
    chk("sat_busy", 32'(busy), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/alus_arbiter.md
Name: alus_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared scalar ALU pair (integer and fixed-point ALUs plus their result/flag muxes).
- Accepts operations from two requesters over valid/ready handshakes and grants them round-robin.
- Drives registered operands and controls into the shared ALU, then returns each result and its flags to the requester that issued the operation.
- Sits between the scalar execute stage (requester 0) and the vector-lane reduction path (requester 1).

Parameters:
- N, 24, operand/result width (matches the ALU's N)
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept, one-hot or zero
- a_0, b_0  in  N each  requester 0 operands
- ctrl_0  in  3  requester 0 ALUControl
- sel_0  in  1  requester 0 ALUSel (0 = integer, 1 = fixed point)
- a_1, b_1, ctrl_1, sel_1  in  N/N/3/1  requester 1 equivalents
- alu_A, alu_B  out  N  operands to the shared ALU
- alu_ALUControl  out  3  to the shared ALU
- alu_ALUSel  out  1  to the shared ALU
- alu_result  in  N  ALU result, combinational from alu_* outputs
- alu_flags  in  4  ALU flags, combinational
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response accept
- rsp_result_0, rsp_result_1  out  N  returned results
- rsp_flags_0, rsp_flags_1  out  4  returned flags
- busy  out  1  issue slot occupied (state EXEC)
- stall_cnt  out  CNT_W  cycles spent in EXEC unable to retire; saturates at all-ones

Behaviour:
- Reset (async, rst=1):
  - all outputs 0, state IDLE
  - last_grant = 1, so requester 0 wins the first contention
  - any in-flight op and pending responses are discarded; nothing is replayed after reset deasserts
- State IDLE: issue slot empty.
- State EXEC: issue registers (alu_A, alu_B, alu_ALUControl, alu_ALUSel, owner) hold one op. The ALU output is evaluated combinationally this cycle.
- Retire condition (EXEC only): owner's response slot is free, i.e. rsp_valid[owner]=0 or rsp_ready[owner]=1.
  - On the retire edge, alu_result and alu_flags are captured into rsp_result_/rsp_flags_[owner], and rsp_valid[owner] is set.
- Slot-free condition:
  - slot_free = (state==IDLE) or (state==EXEC and retire).
  - req_ready is asserted only when slot_free.
  - In EXEC without retire: stall_cnt increments (saturating) and issue registers are held stable.
- Arbitration (combinational, when slot_free):
  - only one req_valid bit set: grant that requester
  - both set: grant ~last_grant
  - req_ready = one-hot grant; a transfer occurs where req_valid & req_ready
  - on transfer: issue registers load the granted requester's a/b/ctrl/sel, owner = granted index, last_grant = granted index, next state EXEC
  - no transfer: slot_free leads to IDLE (issue registers keep their last value), otherwise stay in EXEC
- Throughput: retire and new accept occur on the same edge, giving 1 op/cycle when responses are consumed.
- Latency: request accepted at edge k; the ALU evaluates during cycle k..k+1; rsp_valid rises after edge k+1 (best case 2 edges from request presentation to response visible).
- Response slots:
  - rsp_valid[i] clears on an edge where rsp_ready[i]=1 unless a new retire to i occurs on the same edge, in which case it stays 1 with the new data.
  - rsp data is stable while rsp_valid=1 and rsp_ready=0.
- Independent stalls: a stalled owner blocks the issue slot, so the other requester waits (no bypass). This is intentional, to keep result ordering per requester.
- req_valid must stay high with stable operands until req_ready; deasserting early is a requester protocol violation and is not checked.
- stall_cnt clears only on reset.

Test Plan:
- Single op: req_valid=01, a_0=5, b_0=3, ctrl_0=ADD, sel_0=0.
  -> req_ready=01 in that cycle; alu_A=5 after the edge; rsp_valid=01 with rsp_result_0=8 one edge later.
- Contention from reset: req_valid=11 held.
  -> grants alternate 0,1,0,1 on consecutive edges; rsp_valid alternates 01,10 with each result matching its own operands.
- Back-pressure: rsp_ready_0=0 with a response already pending, plus a new req_0.
  -> op stays in EXEC, busy=1, stall_cnt counts 1,2,3; req_1 is not granted; after rsp_ready_0=1 the op retires and req_1 is granted on the same edge.
- Fixed-point select: sel_1=1 with 0x000100 x 0x000200 operands.
  -> alu_ALUSel=1 during EXEC; rsp_result_1 equals the fixed-point ALU output; rsp_flags_1 equals the fixed-point ALU flags.
- Reset mid-op: assert rst while in EXEC with rsp_valid=01.
  -> all outputs 0 immediately (asynchronous); after release, an idle bench sees no response; the first contention grants requester 0.
- Stall saturation with CNT_W=4: hold the owner stalled for 20 cycles.
  -> stall_cnt stops at 15.
